// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port SRAM arbiter: bus widths and FSM state encoding.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_GAP,
    ST_HI,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter giving two 32-bit requesters access to a 16-bit SRAM,
// splitting every word access into a low half, one idle gap cycle and a high half.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,

  input  logic                     i_a_request,
  input  logic                     i_a_rw,
  input  logic [SRAM_ADDR_W-2:0]   i_a_address,
  input  logic [WORD_W-1:0]        i_a_wdata,
  output logic [WORD_W-1:0]        o_a_rdata,
  output logic                     o_a_ready,

  input  logic                     i_b_request,
  input  logic                     i_b_rw,
  input  logic [SRAM_ADDR_W-2:0]   i_b_address,
  input  logic [WORD_W-1:0]        i_b_wdata,
  output logic [WORD_W-1:0]        o_b_rdata,
  output logic                     o_b_ready,

  output logic                     o_sram_enable,
  output logic                     o_sram_rw,
  output logic [SRAM_ADDR_W-1:0]   o_sram_address,
  output logic [SRAM_DATA_W-1:0]   o_sram_wdata,
  input  logic [SRAM_DATA_W-1:0]   i_sram_rdata,

  output logic                     o_grant
);

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  state_t                   state_q,   state_d;
  logic [3:0]               cnt_q,     cnt_d;
  logic                     owner_q,   owner_d;
  logic                     prio_q,    prio_d;
  logic                     rw_q,      rw_d;
  logic [SRAM_ADDR_W-2:0]   addr_q,    addr_d;
  logic [WORD_W-1:0]        wdata_q,   wdata_d;
  logic [SRAM_DATA_W-1:0]   cap_lo_q,  cap_lo_d;
  logic [WORD_W-1:0]        a_rdata_q, a_rdata_d;
  logic [WORD_W-1:0]        b_rdata_q, b_rdata_d;
  logic                     pick;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cap_lo_d  = cap_lo_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    pick      = (i_a_request && i_b_request) ? prio_q : i_b_request;

    case (state_q)
      ST_IDLE: begin
        if (i_a_request || i_b_request) begin
          owner_d = pick;
          rw_d    = pick ? i_b_rw      : i_a_rw;
          addr_d  = pick ? i_b_address : i_a_address;
          wdata_d = pick ? i_b_wdata   : i_a_wdata;
          cnt_d   = RELOAD;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (cnt_q == 4'd0) begin
          if (!rw_q) cap_lo_d = i_sram_rdata;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        cnt_d   = RELOAD;
        state_d = ST_HI;
      end
      ST_HI: begin
        if (cnt_q == 4'd0) begin
          // The high half is merged straight into the port register so the
          // full word is already visible during the DONE/ready cycle.
          if (!rw_q) begin
            if (owner_q) b_rdata_d = {i_sram_rdata, cap_lo_q};
            else         a_rdata_d = {i_sram_rdata, cap_lo_q};
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        prio_d  = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cap_lo_q  <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cap_lo_q  <= cap_lo_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    o_sram_enable  = 1'b0;
    o_sram_address = '0;
    o_sram_wdata   = '0;
    case (state_q)
      ST_LO: begin
        o_sram_enable  = 1'b1;
        o_sram_address = {addr_q, 1'b0};
        o_sram_wdata   = wdata_q[15:0];
      end
      ST_HI: begin
        o_sram_enable  = 1'b1;
        o_sram_address = {addr_q, 1'b1};
        o_sram_wdata   = wdata_q[31:16];
      end
      default: ;
    endcase
    o_sram_rw = o_sram_enable & rw_q;
    o_a_ready = (state_q == ST_DONE) && !owner_q;
    o_b_ready = (state_q == ST_DONE) &&  owner_q;
    o_a_rdata = a_rdata_q;
    o_b_rdata = b_rdata_q;
    o_grant   = owner_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single transactions plus hand-written
// arbitration, reset-abort and latency sequences at WAIT_CYCLES of 2, 1 and 15.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_rw, b_req, b_rw;
  logic [16:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, b_ready;
  logic        sram_en, sram_rw;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        grant;
  logic [15:0] mod_lo, mod_hi;

  logic [31:0] w1_a_rdata, w1_b_rdata, w15_a_rdata, w15_b_rdata;
  logic        w1_a_ready, w1_b_ready, w15_a_ready, w15_b_ready;
  logic        w1_en, w1_rw, w15_en, w15_rw, w1_grant, w15_grant;
  logic [17:0] w1_addr, w15_addr;
  logic [15:0] w1_wdata, w15_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // SRAM model: low/high half selected by the address LSB
  assign sram_rdata = sram_addr[0] ? mod_hi : mod_lo;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .i_clock(clk), .i_reset_n(reset_n),
    .i_a_request(a_req), .i_a_rw(a_rw), .i_a_address(a_addr), .i_a_wdata(a_wdata),
    .o_a_rdata(a_rdata), .o_a_ready(a_ready),
    .i_b_request(b_req), .i_b_rw(b_rw), .i_b_address(b_addr), .i_b_wdata(b_wdata),
    .o_b_rdata(b_rdata), .o_b_ready(b_ready),
    .o_sram_enable(sram_en), .o_sram_rw(sram_rw), .o_sram_address(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata), .o_grant(grant)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .i_clock(clk), .i_reset_n(reset_n),
    .i_a_request(a_req), .i_a_rw(a_rw), .i_a_address(a_addr), .i_a_wdata(a_wdata),
    .o_a_rdata(w1_a_rdata), .o_a_ready(w1_a_ready),
    .i_b_request(b_req), .i_b_rw(b_rw), .i_b_address(b_addr), .i_b_wdata(b_wdata),
    .o_b_rdata(w1_b_rdata), .o_b_ready(w1_b_ready),
    .o_sram_enable(w1_en), .o_sram_rw(w1_rw), .o_sram_address(w1_addr),
    .o_sram_wdata(w1_wdata), .i_sram_rdata(sram_rdata), .o_grant(w1_grant)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .i_clock(clk), .i_reset_n(reset_n),
    .i_a_request(a_req), .i_a_rw(a_rw), .i_a_address(a_addr), .i_a_wdata(a_wdata),
    .o_a_rdata(w15_a_rdata), .o_a_ready(w15_a_ready),
    .i_b_request(b_req), .i_b_rw(b_rw), .i_b_address(b_addr), .i_b_wdata(b_wdata),
    .o_b_rdata(w15_b_rdata), .o_b_ready(w15_b_ready),
    .o_sram_enable(w15_en), .o_sram_rw(w15_rw), .o_sram_address(w15_addr),
    .o_sram_wdata(w15_wdata), .i_sram_rdata(sram_rdata), .o_grant(w15_grant)
  );

  typedef struct {
    logic        port;
    logic        rw;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [17:0] exp_lo_addr;
    logic [17:0] exp_hi_addr;
    logic [31:0] exp_a_rdata;
    logic [31:0] exp_b_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic port, input logic req, input logic rw,
                       input logic [16:0] addr, input logic [31:0] wdata);
    if (port) begin
      b_req = req; b_rw = rw; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_rw = rw; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req = 0; a_rw = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_rw = 0; b_addr = '0; b_wdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One isolated transaction at WAIT_CYCLES=2: LO 1-2, GAP 3, HI 4-5, DONE 6
  task automatic run_txn(input vec_t v);
    logic en_exp;
    mod_lo = v.lo;
    mod_hi = v.hi;
    drive(v.port, 1'b1, v.rw, v.addr, v.wdata);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) drive(v.port, 1'b1, ~v.rw, ~v.addr, ~v.wdata);
      en_exp = (c == 1 || c == 2 || c == 4 || c == 5);
      check("enable", sram_en, en_exp);
      check("sram_rw", sram_rw, en_exp ? v.rw : 1'b0);
      check("grant", grant, v.port);
      if (en_exp) begin
        check("address", sram_addr, (c < 3) ? v.exp_lo_addr : v.exp_hi_addr);
        if (v.rw) check("wdata", sram_wdata, (c < 3) ? v.wdata[15:0] : v.wdata[31:16]);
      end
      check("a_ready", a_ready, (c == 6) && !v.port);
      check("b_ready", b_ready, (c == 6) &&  v.port);
      if (c == 6) begin
        check("a_rdata", a_rdata, v.exp_a_rdata);
        check("b_rdata", b_rdata, v.exp_b_rdata);
      end
    end
    drive(v.port, 1'b0, 1'b0, '0, '0);
    tick();
    check("idle_enable", sram_en, 1'b0);
    check("idle_ready", a_ready | b_ready, 1'b0);
  endtask

  initial begin
    int lat2, lat1, lat15;
    vec_t v;

    vecs[0] = '{1'b0, 1'b1, 17'h00010, 32'hDEADBEEF, 16'h0000, 16'h0000,
                18'h00020, 18'h00021, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 17'h00010, 32'h00000000, 16'hBEEF, 16'hDEAD,
                18'h00020, 18'h00021, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 17'h1FFFF, 32'h00000000, 16'h1234, 16'h5678,
                18'h3FFFE, 18'h3FFFF, 32'h56781234, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 17'h00000, 32'hCAFEF00D, 16'hAAAA, 16'h5555,
                18'h00000, 18'h00001, 32'h56781234, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 17'h0AAAA, 32'h00000000, 16'hFFFF, 16'h0000,
                18'h15554, 18'h15555, 32'h0000FFFF, 32'hDEADBEEF};

    mod_lo = '0;
    mod_hi = '0;
    do_reset();
    check("rst_enable", sram_en, 1'b0);
    check("rst_rw", sram_rw, 1'b0);
    check("rst_address", sram_addr, 18'h0);
    check("rst_wdata", sram_wdata, 16'h0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst_grant", grant, 1'b0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Simultaneous requests right after reset: A first, B in the next IDLE slot
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 17'h00001, 32'h11112222);
    drive(1'b1, 1'b1, 1'b1, 17'h00002, 32'h33334444);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) check("simul_grant_a", grant, 1'b0);
      if (c == 6) begin
        check("simul_a_ready", a_ready, 1'b1);
        check("simul_b_wait", b_ready, 1'b0);
        a_req = 1'b0;
      end
      if (c == 7) check("simul_idle", sram_en, 1'b0);
      if (c == 8) begin
        check("simul_grant_b", grant, 1'b1);
        check("simul_b_addr", sram_addr, 18'h00004);
      end
      if (c == 13) begin
        check("simul_b_ready", b_ready, 1'b1);
        check("simul_a_quiet", a_ready, 1'b0);
        b_req = 1'b0;
      end
    end
    tick();

    // Both held continuously: grants alternate A,B,A,B
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 17'h00003, 32'hA5A5A5A5);
    drive(1'b1, 1'b1, 1'b1, 17'h00004, 32'h5A5A5A5A);
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (c % 7 == 1) check("rr_grant", grant, logic'((c / 7) % 2));
      if (c % 7 == 6) begin
        check("rr_a_ready", a_ready, logic'((c / 7) % 2 == 0));
        check("rr_b_ready", b_ready, logic'((c / 7) % 2 == 1));
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();

    // Reset asserted during HI of a write aborts it without ready
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 17'h00100, 32'h12345678);
    for (int c = 1; c <= 4; c++) tick();
    check("abort_hi_enable", sram_en, 1'b1);
    check("abort_hi_addr", sram_addr, 18'h00201);
    reset_n = 1'b0;
    tick();
    check("abort_enable", sram_en, 1'b0);
    check("abort_ready", a_ready | b_ready, 1'b0);
    reset_n = 1'b1;
    a_req = 1'b0;
    tick();
    check("abort_no_late_ready", a_ready, 1'b0);
    v = '{1'b0, 1'b0, 17'h00100, 32'h00000000, 16'h1111, 16'h2222,
          18'h00200, 18'h00201, 32'h22221111, 32'h00000000};
    run_txn(v);

    // Latency across WAIT_CYCLES settings
    do_reset();
    lat2 = 0; lat1 = 0; lat15 = 0;
    drive(1'b0, 1'b1, 1'b0, 17'h00005, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (a_ready     && lat2  == 0) lat2  = n;
      if (w1_a_ready  && lat1  == 0) lat1  = n;
      if (w15_a_ready && lat15 == 0) lat15 = n;
    end
    check("latency_w2", lat2, 6);
    check("latency_w1", lat1, 4);
    check("latency_w15", lat15, 32);
    a_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES SHALL be: WAIT_CYCLES, default 2, clocks each 16-bit half-access is held (legal range 1..15).
REQ-002 Port i_clock SHALL be: i_clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port i_reset_n SHALL be: i_reset_n  in  1  reset, synchronous and active-low.
REQ-004 Port A request inputs SHALL be: i_a_request in 1 (level) / i_a_rw in 1 (1=write) / i_a_address in 17 (32-bit word address) / i_a_wdata in 32.
REQ-005 Port A response outputs SHALL be: o_a_rdata out 32 (read result) / o_a_ready out 1 (one-cycle completion pulse).
REQ-006 Port B SHALL have identical signals named i_b_request, i_b_rw, i_b_address, i_b_wdata, o_b_rdata, o_b_ready.
REQ-007 SRAM-side outputs SHALL be: o_sram_enable out 1 / o_sram_rw out 1 / o_sram_address out 18 / o_sram_wdata out 16.
REQ-008 SRAM-side input SHALL be: i_sram_rdata in 16 (read data from the SRAM interface).
REQ-009 Port o_grant SHALL be: o_grant out 1, owner of the current transaction (0=A, 1=B), valid while not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, LO, GAP, HI, DONE.
REQ-011 IDLE: if any request is high, the FSM SHALL latch owner, rw, address and wdata and go to LO; otherwise it SHALL stay in IDLE.
REQ-012 When both requests are high in IDLE, the grant SHALL go to the port holding the round-robin priority; after a transaction completes, priority SHALL pass to the other port.
REQ-013 LO: o_sram_enable=1, o_sram_address={addr,1'b0}, o_sram_wdata=wdata[15:0]; held WAIT_CYCLES cycles; then the FSM SHALL go to GAP.
REQ-014 GAP: o_sram_enable=0 for exactly 1 cycle (separate write strobes); then the FSM SHALL go to HI.
REQ-015 HI: o_sram_enable=1, o_sram_address={addr,1'b1}, o_sram_wdata=wdata[31:16]; held WAIT_CYCLES cycles; then the FSM SHALL go to DONE.
REQ-016 On reads, i_sram_rdata SHALL be captured on the last cycle of LO into bits [15:0] and on the last cycle of HI into bits [31:16].
REQ-017 DONE: the owner's ready SHALL be 1 for exactly 1 cycle; the owner's rdata SHALL update from the capture register; the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be fixed: request sampled in IDLE at cycle 0 -> ready in cycle 2*WAIT_CYCLES+2 (cycle 6 at the default).
REQ-019 Handshake: the requester SHALL hold request and operands stable until ready and deassert request on the edge ending the ready cycle; the arbiter ignores operand changes after the latch.
REQ-020 A request still high in the IDLE cycle after its DONE SHALL be treated as a new transaction.
REQ-021 The non-owner's request SHALL wait with no timeout; it is granted on the next IDLE cycle.
REQ-022 o_sram_rw SHALL equal the latched rw whenever o_sram_enable=1 and SHALL be 0 otherwise.
REQ-023 o_x_rdata SHALL hold its value until that port's next read completes; writes SHALL leave it unchanged.
REQ-024 The wait counter SHALL be 4 bits, reload to WAIT_CYCLES-1 on entry to LO/HI, and never wrap.

Reset
REQ-025 With i_reset_n=0 at an edge: state=IDLE, priority=A, o_sram_enable=0, o_sram_rw=0, o_sram_address=0, o_sram_wdata=0, o_a/b_ready=0, o_a/b_rdata=0, o_grant=0.
REQ-026 Reset mid-transaction SHALL abort it without issuing ready; a write may be partially done.

Structure
REQ-027 A shared package sram_pkg SHALL hold the state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16 and WORD_W=32.
REQ-028 No sub-module is required; the round-robin pick SHALL be inline, and the SRAM_interface instance SHALL live beside this block in the parent.

Verification
REQ-029 Scenario: A writes 0xDEADBEEF to 0x00010 -> enable cycles 1-2 at addr 0x00020 data 0xBEEF, gap cycle 3, cycles 4-5 at 0x00021 data 0xDEAD, o_a_ready cycle 6.
REQ-030 Scenario: B reads 0x00010 with the model returning 0xBEEF/0xDEAD -> o_b_rdata=0xDEADBEEF at ready, o_b_ready pulse 1 cycle.
REQ-031 Scenario: A and B requested in the same cycle after reset -> A served first (grant 0), B served immediately after (grant 1).
REQ-032 Scenario: A and B held continuously for 4 transactions -> grants alternate A,B,A,B.
REQ-033 Scenario: i_reset_n=0 during HI of a write -> next cycle enable=0 and no ready; a later request completes normally.
REQ-034 Scenario: WAIT_CYCLES=1 -> ready in cycle 4; WAIT_CYCLES=15 -> ready in cycle 32.
